// File: rtl/usb_rx_core.sv
// usb_rx_core: full-speed USB packet receiver. Synchronises D+/D-, recovers bit timing from
// D+ edges, NRZI-decodes, removes stuffed bits, frames SYNC/EOP and buffers payload bytes
// in a first-word fall-through FIFO.
module usb_rx_core #(
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter int unsigned SAMPLE_PHASE = 3,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        d_plus,
  input  logic                        d_minus,
  input  logic                        r_enable,
  output logic [7:0]                  r_data,
  output logic                        empty,
  output logic                        full,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        rcving,
  output logic                        r_error,
  output logic                        pkt_done,
  output logic [7:0]                  pkt_bytes
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] LastTick = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] SamplePt = TW'(SAMPLE_PHASE);
  localparam logic [AW:0]   FullCnt  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {StIdle, StSync, StRecv, StEop1, StEop2, StErr} state_e;
  state_e state_q, state_d;

  logic [1:0]    dp_sync_q, dm_sync_q;
  logic          dp_prev_q;
  logic [TW-1:0] timer_q;
  logic          last_dp_q;
  logic [2:0]    ones_q, bit_cnt_q, j_cnt_q;
  logic [6:0]    shift_q;
  logic          err_se0_q;
  logic          r_error_q, pkt_done_q;
  logic [7:0]    pkt_bytes_q, acc_cnt_q;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q;

  logic dp_s, dm_s, line_se0, line_j, line_k, dp_edge, sample, bit_state;
  logic nrzi_bit, stuff_drop, stuff_err, byte_done;
  logic [7:0] new_byte;
  logic go_sync, eop_ok, enter_err, push_req, do_push, do_pop, fifo_full, overflow;

  assign dp_s      = dp_sync_q[1];
  assign dm_s      = dm_sync_q[1];
  assign line_se0  = !dp_s && !dm_s;
  assign line_k    = !dp_s && dm_s;
  assign line_j    = dp_s;            // (1,1) folds into J
  assign dp_edge   = dp_s ^ dp_prev_q;
  assign sample    = (timer_q == SamplePt);
  assign bit_state = (state_q == StSync) || (state_q == StRecv);

  assign nrzi_bit   = (dp_s == last_dp_q);
  assign stuff_drop = (ones_q == 3'd6) && !nrzi_bit;
  assign stuff_err  = (ones_q == 3'd6) && nrzi_bit;
  assign new_byte   = {nrzi_bit, shift_q};
  assign byte_done  = sample && !line_se0 && !stuff_drop && !stuff_err && (bit_cnt_q == 3'd7);

  assign go_sync   = (state_q == StIdle) && (state_d == StSync);
  assign eop_ok    = (state_q == StEop2) && (state_d == StIdle);
  assign enter_err = (state_q != StErr) && (state_d == StErr);

  assign push_req  = (state_q == StRecv) && byte_done;
  assign fifo_full = (cnt_q == FullCnt);
  assign do_pop    = r_enable && (cnt_q != '0);
  assign do_push   = push_req && (!fifo_full || do_pop);
  assign overflow  = push_req && fifo_full && !do_pop;

  // Two-flop synchronisers plus a delayed D+ copy for edge detection; idle line is J.
  always_ff @(posedge clk) begin
    if (rst) begin
      dp_sync_q <= 2'b11;
      dm_sync_q <= 2'b00;
      dp_prev_q <= 1'b1;
    end else begin
      dp_sync_q <= {dp_sync_q[0], d_plus};
      dm_sync_q <= {dm_sync_q[0], d_minus};
      dp_prev_q <= dp_sync_q[1];
    end
  end

  // Bit timer: free-running modulo counter, realigned on every D+ transition.
  always_ff @(posedge clk) begin
    if (rst || dp_edge) begin
      timer_q <= '0;
    end else if (timer_q == LastTick) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + TW'(1);
    end
  end

  // NRZI history, ones run for unstuffing and the LSB-first byte shifter.
  always_ff @(posedge clk) begin
    if (rst || state_q == StIdle) begin
      last_dp_q <= 1'b1;
      ones_q    <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else if (sample && bit_state && !line_se0) begin
      last_dp_q <= dp_s;
      if (stuff_drop) begin
        ones_q <= '0;
      end else begin
        ones_q    <= nrzi_bit ? ones_q + 3'd1 : 3'd0;
        shift_q   <= new_byte[7:1];
        bit_cnt_q <= bit_cnt_q + 3'd1;
      end
    end
  end

  // Error recovery tracking: SE0 seen, and length of the current J run.
  always_ff @(posedge clk) begin
    if (rst || state_q != StErr) begin
      err_se0_q <= 1'b0;
      j_cnt_q   <= '0;
    end else if (sample) begin
      if (line_se0) begin
        err_se0_q <= 1'b1;
        j_cnt_q   <= '0;
      end else if (line_j) begin
        if (j_cnt_q != 3'd7) j_cnt_q <= j_cnt_q + 3'd1;
      end else begin
        err_se0_q <= 1'b0;
        j_cnt_q   <= '0;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (line_k && dp_prev_q) state_d = StSync;
      StSync: begin
        if (sample) begin
          if (line_se0 || stuff_err) state_d = StErr;
          else if (byte_done)        state_d = (new_byte == 8'h80) ? StRecv : StErr;
        end
      end
      StRecv: begin
        if (sample) begin
          if (line_se0)       state_d = (bit_cnt_q == 3'd0) ? StEop1 : StErr;
          else if (stuff_err) state_d = StErr;
        end
      end
      StEop1: if (sample) state_d = line_se0 ? StEop2 : StErr;
      StEop2: if (sample) state_d = line_j ? StIdle : StErr;
      StErr:  if (sample && line_j && (err_se0_q || j_cnt_q == 3'd7)) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Packet status: sticky error, completion strobe and accepted-byte count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_error_q   <= 1'b0;
      pkt_done_q  <= 1'b0;
      pkt_bytes_q <= '0;
      acc_cnt_q   <= '0;
    end else begin
      pkt_done_q <= eop_ok;
      if (eop_ok) pkt_bytes_q <= acc_cnt_q;
      if (go_sync) acc_cnt_q <= '0;
      else if (do_push && acc_cnt_q != 8'hFF) acc_cnt_q <= acc_cnt_q + 8'd1;
      if (go_sync) r_error_q <= 1'b0;
      else if (enter_err || overflow) r_error_q <= 1'b1;
    end
  end

  // FIFO pointers and occupancy; simultaneous push/pop when full is not an overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      if (do_push && !do_pop)      cnt_q <= cnt_q + (AW + 1)'(1);
      else if (!do_push && do_pop) cnt_q <= cnt_q - (AW + 1)'(1);
    end
  end

  // FIFO storage; contents are don't-care while the matching count is zero.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= new_byte;
  end

  // Outputs.
  always_comb begin
    rcving    = (state_q != StIdle);
    empty     = (cnt_q == '0);
    full      = fifo_full;
    count     = cnt_q;
    r_data    = empty ? 8'h00 : mem_q[rptr_q];
    r_error   = r_error_q;
    pkt_done  = pkt_done_q;
    pkt_bytes = pkt_bytes_q;
  end

endmodule

// File: tb/tb_usb_rx_core.sv
// tb_usb_rx_core: directed packets driven as line symbols; a queue model of the FIFO and
// packet report is checked every cycle by one monitor, plus literal checks per scenario.
module tb_usb_rx_core;
  localparam int Cpb   = 8;
  localparam int Phase = 3;
  localparam int Depth = 4;
  localparam logic [1:0] SymJ   = 2'b10;
  localparam logic [1:0] SymK   = 2'b01;
  localparam logic [1:0] SymSe0 = 2'b00;

  logic       tb_clk = 1'b0;
  logic       rst, d_plus, d_minus, r_enable;
  logic [7:0] r_data, pkt_bytes;
  logic       empty, full, rcving, r_error, pkt_done;
  logic [$clog2(Depth):0] count;

  usb_rx_core #(
    .CLKS_PER_BIT(Cpb),
    .SAMPLE_PHASE(Phase),
    .FIFO_DEPTH  (Depth)
  ) dut (
    .clk      (tb_clk),
    .rst      (rst),
    .d_plus   (d_plus),
    .d_minus  (d_minus),
    .r_enable (r_enable),
    .r_data   (r_data),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .rcving   (rcving),
    .r_error  (r_error),
    .pkt_done (pkt_done),
    .pkt_bytes(pkt_bytes)
  );

  always #50 tb_clk = ~tb_clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Model state: expected FIFO contents and packet report.
  logic [7:0] exp_q[$];
  logic [7:0] pkt_data[$];
  int exp_done_bytes  = 0;
  int model_pkt_bytes = 0;
  int done_seen       = 0;
  bit quiet           = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: completion report always; FIFO state and popped data whenever the line is quiet.
  always @(negedge tb_clk) begin
    if (!rst) begin
      if (pkt_done) begin
        done_seen++;
        check("pkt_bytes_at_done", pkt_bytes, exp_done_bytes);
      end
      if (quiet) begin
        check("count", count, exp_q.size());
        check("empty", empty, exp_q.size() == 0);
        check("full", full, exp_q.size() == Depth);
        if (exp_q.size() == 0) check("r_data_empty", r_data, 8'h00);
        if (r_enable && exp_q.size() > 0) begin
          check("r_data", r_data, exp_q[0]);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // Encode SYNC + payload (optionally truncated to nbits) + EOP, drive it, update the model.
  task automatic run_pkt(input logic [7:0] sync_b, input int nbits, input bit stuff,
                         input int period, input int exp_push, input bit exp_done,
                         input bit exp_err);
    logic [1:0] syms[$];
    bit bits[$];
    bit lvl;
    bit ovf;
    int ones, room, acc, old_done, ndata;
    ndata = (nbits < 0) ? pkt_data.size() * 8 : nbits;
    for (int i = 0; i < 8; i++) bits.push_back(sync_b[i]);
    for (int i = 0; i < ndata; i++) bits.push_back(pkt_data[i / 8][i % 8]);
    lvl  = 1'b1;
    ones = 0;
    foreach (bits[i]) begin
      if (bits[i]) begin
        syms.push_back(lvl ? SymJ : SymK);
        ones++;
        if (stuff && ones == 6) begin
          lvl = !lvl;
          syms.push_back(lvl ? SymJ : SymK);
          ones = 0;
        end
      end else begin
        lvl = !lvl;
        syms.push_back(lvl ? SymJ : SymK);
        ones = 0;
      end
    end
    syms.push_back(SymSe0);
    syms.push_back(SymSe0);
    syms.push_back(SymJ);

    room = Depth - exp_q.size();
    acc  = (exp_push < room) ? exp_push : room;
    ovf  = (exp_push > room);
    exp_done_bytes = acc;
    old_done = done_seen;
    quiet = 1'b0;
    foreach (syms[i]) begin
      {d_plus, d_minus} = syms[i];
      #(period);
      if (i == 8) begin
        check("rcving_mid", rcving, 1);
        if (sync_b == 8'h80) check("err_clr_at_sync", r_error, 0);
      end
    end
    #(3 * period);
    repeat (4) @(posedge tb_clk);
    #1;
    for (int i = 0; i < acc; i++) exp_q.push_back(pkt_data[i]);
    if (exp_done) model_pkt_bytes = acc;
    quiet = 1'b1;
    check("done_pulses", done_seen - old_done, exp_done);
    check("r_error_end", r_error, exp_err | ovf);
    check("rcving_end", rcving, 0);
    check("pkt_bytes", pkt_bytes, model_pkt_bytes);
  endtask

  // Hold r_enable for n consecutive cycles.
  task automatic drain(input int n);
    @(posedge tb_clk);
    #1 r_enable = 1'b1;
    repeat (n) @(posedge tb_clk);
    #1 r_enable = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    d_plus   = 1'b1;
    d_minus  = 1'b0;
    r_enable = 1'b0;
    @(posedge tb_clk);
    @(negedge tb_clk);
    check("rst_r_data", r_data, 8'h00);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    check("rst_rcving", rcving, 0);
    check("rst_r_error", r_error, 0);
    check("rst_pkt_done", pkt_done, 0);
    check("rst_pkt_bytes", pkt_bytes, 8'h00);
    @(posedge tb_clk);
    #1 rst = 1'b0;
    quiet = 1'b1;
    repeat (4) @(posedge tb_clk);
    #1;

    // Nominal packet.
    pkt_data = '{8'hA5, 8'h3C};
    run_pkt(8'h80, -1, 1'b1, 800, 2, 1'b1, 1'b0);
    check("nom_head", r_data, 8'hA5);
    check("nom_pkt_bytes", pkt_bytes, 8'd2);
    check("nom_count", count, 2);
    drain(2);

    // Bit stuffing present, then the same stream without the stuffed bits.
    pkt_data = '{8'hFF, 8'h7E};
    run_pkt(8'h80, -1, 1'b1, 800, 2, 1'b1, 1'b0);
    check("stf_head", r_data, 8'hFF);
    drain(2);
    run_pkt(8'h80, -1, 1'b0, 800, 0, 1'b0, 1'b1);
    check("nostf_pkt_bytes", pkt_bytes, 8'd2);
    check("nostf_empty", empty, 1);

    // Bad SYNC, then a valid packet that recovers.
    pkt_data = '{8'h00};
    run_pkt(8'h81, -1, 1'b1, 800, 0, 1'b0, 1'b1);
    check("badsync_err", r_error, 1);
    check("badsync_empty", empty, 1);
    pkt_data = '{8'h5A};
    run_pkt(8'h80, -1, 1'b1, 800, 1, 1'b1, 1'b0);
    check("recover_head", r_data, 8'h5A);
    check("recover_err", r_error, 0);
    drain(1);

    // Overflow with reads held off, then back-to-back pops past empty.
    pkt_data = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    run_pkt(8'h80, -1, 1'b1, 800, 5, 1'b1, 1'b0);
    check("ovf_full", full, 1);
    check("ovf_count", count, 4);
    check("ovf_pkt_bytes", pkt_bytes, 8'd4);
    check("ovf_err", r_error, 1);
    check("ovf_head", r_data, 8'h01);
    drain(6);
    check("ovf_drained", empty, 1);

    // Bit period skew, both directions.
    pkt_data = '{8'hA5, 8'h3C};
    run_pkt(8'h80, -1, 1'b1, 772, 2, 1'b1, 1'b0);
    check("slow_head", r_data, 8'hA5);
    check("slow_pkt_bytes", pkt_bytes, 8'd2);
    drain(2);
    run_pkt(8'h80, -1, 1'b1, 828, 2, 1'b1, 1'b0);
    check("fast_head", r_data, 8'hA5);
    check("fast_pkt_bytes", pkt_bytes, 8'd2);
    drain(2);

    // Premature SE0 after four data bits.
    run_pkt(8'h80, 4, 1'b1, 800, 0, 1'b0, 1'b1);
    check("early_se0_err", r_error, 1);
    check("early_se0_empty", empty, 1);

    repeat (4) @(posedge tb_clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
